// File: rtl/pixel_frame_buffer_pkg.sv
// Shared definitions for the DVP RX write path: AXI response codes,
// write-slave FSM state encoding and small helper functions.
package pixel_frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } pfb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_code(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

  // Width able to hold 0..words-1, never narrower than one bit.
  function automatic int cnt_width(input int words);
    return (words > 32'sd1) ? $clog2(words) : 32'sd1;
  endfunction

endpackage

// File: rtl/pixel_frame_buffer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DVP RX master and the
// frame buffer slave.
interface pixel_frame_buffer_if #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MST_ID_W     = 5,
  parameter int TRANS_RESP_W = 2
);
  logic [MST_ID_W-1:0]     s_awid_i;
  logic [ADDR_W-1:0]       s_awaddr_i;
  logic                    s_awvalid_i;
  logic                    s_awready_o;
  logic [DATA_W-1:0]       s_wdata_i;
  logic                    s_wlast_i;
  logic                    s_wvalid_i;
  logic                    s_wready_o;
  logic [MST_ID_W-1:0]     s_bid_o;
  logic [TRANS_RESP_W-1:0] s_bresp_o;
  logic                    s_bvalid_o;
  logic                    s_bready_i;

  modport master (
    output s_awid_i, s_awaddr_i, s_awvalid_i, s_wdata_i, s_wlast_i, s_wvalid_i, s_bready_i,
    input  s_awready_o, s_wready_o, s_bid_o, s_bresp_o, s_bvalid_o
  );

  modport slave (
    input  s_awid_i, s_awaddr_i, s_awvalid_i, s_wdata_i, s_wlast_i, s_wvalid_i, s_bready_i,
    output s_awready_o, s_wready_o, s_bid_o, s_bresp_o, s_bvalid_o
  );
endinterface

// File: rtl/pixel_frame_buffer_frame_word_counter.sv
// Counts successful SRAM writes and emits a one-cycle done pulse that lines up
// with the registered write strobe of the frame's final word.
module frame_word_counter
  import pixel_frame_buffer_pkg::*;
#(
  parameter int FRAME_WORDS = 4800
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  output logic done_o
);
  localparam int CNT_W = cnt_width(FRAME_WORDS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             last_s;

  assign last_s = (count_q == CNT_W'(FRAME_WORDS - 1));
  assign done_o = done_q;

  // Next count: wrap to zero on the frame's last word and flag done.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (inc_i) begin
      if (last_s) begin
        count_d = {CNT_W{1'b0}};
        done_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// AXI4 write slave that lands DVP pixel bursts in a word-addressed SRAM and
// flags each completed frame.
module pixel_frame_buffer
  import pixel_frame_buffer_pkg::*;
#(
  parameter int              DATA_W       = 32,
  parameter int              ADDR_W       = 32,
  parameter int              MST_ID_W     = 5,
  parameter int              TRANS_RESP_W = 2,
  parameter int              MEM_ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h2000_0000),
  parameter int              FRAME_WORDS  = 4800
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pixel_frame_buffer_if.slave   s_axi,
  output logic                  mem_wr_en_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic                  frame_done_o
);

  pfb_state_e              state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [MST_ID_W-1:0]     bid_q, bid_d;
  logic [TRANS_RESP_W-1:0] bresp_q, bresp_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    addr_bad_q, addr_bad_d;
  logic                    err_q, err_d;
  logic                    wr_en_q, wr_en_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;

  logic aw_hs_s, w_hs_s, b_hs_s, beat_oor_s;

  // Word indices at or above the SRAM depth have bits set above MEM_ADDR_W.
  function automatic logic idx_out_of_range(input logic [ADDR_W-1:0] idx);
    return (idx >> MEM_ADDR_W) != {ADDR_W{1'b0}};
  endfunction

  assign aw_hs_s    = s_axi.s_awvalid_i & awready_q;
  assign w_hs_s     = s_axi.s_wvalid_i & wready_q;
  assign b_hs_s     = s_axi.s_bready_i & bvalid_q;
  assign beat_oor_s = addr_bad_q | idx_out_of_range(idx_q);

  assign s_axi.s_awready_o = awready_q;
  assign s_axi.s_wready_o  = wready_q;
  assign s_axi.s_bvalid_o  = bvalid_q;
  assign s_axi.s_bid_o     = bid_q;
  assign s_axi.s_bresp_o   = bresp_q;
  assign mem_wr_en_o       = wr_en_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;

  // FSM next state, beat addressing, error tracking and SRAM write staging.
  always_comb begin
    state_d     = state_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    idx_d       = idx_q;
    addr_bad_d  = addr_bad_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs_s) begin
          state_d    = ST_DATA;
          bid_d      = s_axi.s_awid_i;
          idx_d      = (s_axi.s_awaddr_i - BASE_ADDR) >> 2'd2;
          addr_bad_d = (s_axi.s_awaddr_i < BASE_ADDR) | (s_axi.s_awaddr_i[1:0] != 2'b00);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (w_hs_s) begin
          idx_d = idx_q + ADDR_W'(1);
          // Out-of-range beats are swallowed; only the sticky flag records them.
          if (beat_oor_s) begin
            err_d = 1'b1;
          end else begin
            wr_en_d     = 1'b1;
            mem_addr_d  = idx_q[MEM_ADDR_W-1:0];
            mem_wdata_d = s_axi.s_wdata_i;
          end
          if (s_axi.s_wlast_i) begin
            state_d = ST_RESP;
            bresp_d = TRANS_RESP_W'(resp_code(err_q | beat_oor_s));
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        if (b_hs_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_DATA);
    bvalid_d  = (state_d == ST_RESP);
  end

  // State, handshake outputs and SRAM port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= {MST_ID_W{1'b0}};
      bresp_q     <= {TRANS_RESP_W{1'b0}};
      idx_q       <= {ADDR_W{1'b0}};
      addr_bad_q  <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_addr_q  <= {MEM_ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      idx_q       <= idx_d;
      addr_bad_q  <= addr_bad_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  frame_word_counter #(
    .FRAME_WORDS(FRAME_WORDS)
  ) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (wr_en_d),
    .done_o(frame_done_o)
  );

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer with a transaction-level reference model
// and a per-cycle comparator, using a small SRAM and short frame.
module tb_pixel_frame_buffer;
  localparam int          DATA_W       = 32;
  localparam int          ADDR_W       = 32;
  localparam int          MST_ID_W     = 5;
  localparam int          TRANS_RESP_W = 2;
  localparam int          MEM_ADDR_W   = 4;
  localparam int          FRAME_WORDS  = 8;
  localparam logic [31:0] BASE         = 32'h2000_0000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mem_wr_en_o;
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic                  frame_done_o;

  pixel_frame_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MST_ID_W(MST_ID_W),
                          .TRANS_RESP_W(TRANS_RESP_W)) bus ();

  pixel_frame_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MST_ID_W(MST_ID_W), .TRANS_RESP_W(TRANS_RESP_W),
    .MEM_ADDR_W(MEM_ADDR_W), .BASE_ADDR(BASE), .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axi(bus), .mem_wr_en_o(mem_wr_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic longint beat_idx(input logic [31:0] a, input int n);
    return (longint'(a) - longint'(BASE)) / 4 + longint'(n);
  endfunction

  function automatic bit beat_ok(input logic [31:0] a, input int n);
    if (a < BASE) return 1'b0;
    if (a[1:0] != 2'b00) return 1'b0;
    return beat_idx(a, n) < (longint'(1) << MEM_ADDR_W);
  endfunction

  logic [31:0] m_awaddr;
  int          m_beat;
  bit          m_err, m_in_burst;
  bit          exp_wr, exp_done;
  int          exp_cnt;
  logic [31:0] exp_addr, exp_data;
  logic [4:0]  exp_bid;
  logic [1:0]  exp_bresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_awaddr <= 32'd0; m_beat <= 0; m_err <= 1'b0; m_in_burst <= 1'b0;
      exp_wr <= 1'b0; exp_done <= 1'b0; exp_cnt <= 0;
      exp_addr <= 32'd0; exp_data <= 32'd0; exp_bid <= 5'd0; exp_bresp <= 2'd0;
    end else begin
      exp_wr   <= 1'b0;
      exp_done <= 1'b0;
      if (bus.s_awvalid_i && bus.s_awready_o) begin
        m_awaddr <= bus.s_awaddr_i; exp_bid <= bus.s_awid_i;
        m_beat <= 0; m_err <= 1'b0; m_in_burst <= 1'b1;
      end
      if (bus.s_wvalid_i && bus.s_wready_o) begin
        m_beat <= m_beat + 1;
        if (beat_ok(m_awaddr, m_beat)) begin
          exp_wr   <= 1'b1;
          exp_addr <= 32'(beat_idx(m_awaddr, m_beat));
          exp_data <= bus.s_wdata_i;
          exp_done <= (exp_cnt + 1 == FRAME_WORDS);
          exp_cnt  <= (exp_cnt + 1) % FRAME_WORDS;
        end else begin
          m_err <= 1'b1;
        end
        if (bus.s_wlast_i) begin
          m_in_burst <= 1'b0;
          exp_bresp  <= (m_err || !beat_ok(m_awaddr, m_beat)) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // ---------------- per-cycle comparator and write log ----------------
  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  wr_t wr_log[$];
  int  n_done  = 0;
  int  done_at = 0;

  always @(negedge clk) begin
    chk("ready_exclusive", 64'($countones({bus.s_awready_o, bus.s_wready_o, bus.s_bvalid_o}) <= 1), 64'd1);
    chk("mem_wr_en", mem_wr_en_o, exp_wr);
    if (exp_wr) begin
      chk("mem_addr", mem_addr_o, exp_addr);
      chk("mem_wdata", mem_wdata_o, exp_data);
    end
    chk("frame_done", frame_done_o, exp_done);
    chk("frame_cnt", dut.u_frame_cnt.count_q, exp_cnt);
    if (bus.s_wready_o) chk("wready_only_in_burst", m_in_burst, 1'b1);
    if (bus.s_bvalid_o) begin
      chk("bid", bus.s_bid_o, exp_bid);
      chk("bresp", bus.s_bresp_o, exp_bresp);
    end
    if (mem_wr_en_o) wr_log.push_back('{int'(mem_addr_o), int'(mem_wdata_o)});
    if (frame_done_o) begin
      n_done++;
      done_at = wr_log.size();
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_aw(input logic [4:0] id, input logic [31:0] addr);
    int k = 0;
    bus.s_awid_i = id; bus.s_awaddr_i = addr; bus.s_awvalid_i = 1'b1;
    while (!bus.s_awready_o && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) chk("aw_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    bus.s_awvalid_i = 1'b0;
  endtask

  task automatic send_beats(input int n_send, input int n_total, input logic [31:0] d0);
    for (int i = 0; i < n_send; i++) begin
      int k = 0;
      bus.s_wdata_i = d0 + 32'(i); bus.s_wlast_i = (i == n_total - 1); bus.s_wvalid_i = 1'b1;
      while (!bus.s_wready_o && k < 50) begin @(posedge clk); #1; k++; end
      if (k >= 50) chk("w_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
    end
    bus.s_wvalid_i = 1'b0; bus.s_wlast_i = 1'b0;
  endtask

  task automatic wait_b(input int hold, output logic [4:0] bid, output logic [1:0] bresp);
    int k = 0;
    while (!bus.s_bvalid_o && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) chk("b_timeout", 64'd1, 64'd0);
    for (int h = 0; h < hold; h++) begin
      chk("awready_low_in_resp", bus.s_awready_o, 1'b0);
      chk("bvalid_held", bus.s_bvalid_o, 1'b1);
      @(posedge clk); #1;
    end
    bid = bus.s_bid_o; bresp = bus.s_bresp_o;
    bus.s_bready_i = 1'b1;
    @(posedge clk); #1;
    bus.s_bready_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_awready"}, bus.s_awready_o, 1'b1);
    chk({tag, "_wready"}, bus.s_wready_o, 1'b0);
    chk({tag, "_bvalid"}, bus.s_bvalid_o, 1'b0);
    chk({tag, "_bid"}, bus.s_bid_o, 5'd0);
    chk({tag, "_bresp"}, bus.s_bresp_o, 2'd0);
    chk({tag, "_wr_en"}, mem_wr_en_o, 1'b0);
    chk({tag, "_addr"}, mem_addr_o, 4'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_done"}, frame_done_o, 1'b0);
    chk({tag, "_cnt"}, dut.u_frame_cnt.count_q, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] bid;
    logic [1:0] bresp;
    int base;
    bus.s_awid_i = 5'd0; bus.s_awaddr_i = 32'd0; bus.s_awvalid_i = 1'b0;
    bus.s_wdata_i = 32'd0; bus.s_wlast_i = 1'b0; bus.s_wvalid_i = 1'b0; bus.s_bready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four beats at 0x2000_0010 land in words 4..7.
    base = wr_log.size();
    send_aw(5'd3, 32'h2000_0010);
    send_beats(4, 4, 32'hD000_0000);
    wait_b(0, bid, bresp);
    chk("t1_bid", bid, 5'd3);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_nwr", wr_log.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", wr_log[base+i].addr, 4 + i);
      chk("t1_data", wr_log[base+i].data, 32'hD000_0000 + i);
    end
    chk("t1_no_done", n_done, 0);

    // Second 4-beat burst completes the 8-word frame.
    send_aw(5'd1, 32'h2000_0000);
    send_beats(4, 4, 32'hE000_0000);
    wait_b(0, bid, bresp);
    chk("t2_ndone", n_done, 1);
    chk("t2_done_at", done_at, 8);
    chk("t2_cnt_zero", dut.u_frame_cnt.count_q, 3'd0);

    // Below the window: accepted, nothing written, SLVERR.
    base = wr_log.size();
    send_aw(5'd2, 32'h1FFF_FFFC);
    send_beats(2, 2, 32'h1111_0000);
    wait_b(0, bid, bresp);
    chk("t3_bresp", bresp, 2'b10);
    chk("t3_nwr", wr_log.size(), base);
    chk("t3_idle", bus.s_awready_o, 1'b1);

    // Run off the end of a 16-word SRAM.
    base = wr_log.size();
    send_aw(5'd4, 32'h2000_0038);
    send_beats(4, 4, 32'h2222_0000);
    wait_b(0, bid, bresp);
    chk("t4_bresp", bresp, 2'b10);
    chk("t4_nwr", wr_log.size(), base + 2);
    chk("t4_addr0", wr_log[base].addr, 14);
    chk("t4_addr1", wr_log[base+1].addr, 15);

    // Single-beat burst; B held 3 cycles with AW already pending.
    send_aw(5'd5, 32'h2000_0020);
    send_beats(1, 1, 32'h3333_0000);
    bus.s_awid_i = 5'd6; bus.s_awaddr_i = 32'h2000_0024; bus.s_awvalid_i = 1'b1;
    wait_b(3, bid, bresp);
    chk("t5_bid", bid, 5'd5);
    chk("t5_bresp", bresp, 2'b00);
    chk("t5_awready_after_b", bus.s_awready_o, 1'b1);
    @(posedge clk); #1;
    bus.s_awvalid_i = 1'b0;
    chk("t5_aw_taken", bus.s_wready_o, 1'b1);
    send_beats(2, 2, 32'h4444_0000);
    wait_b(0, bid, bresp);
    chk("t5b_bid", bid, 5'd6);

    // W presented before AW is held off, then taken.
    base = wr_log.size();
    bus.s_wdata_i = 32'h5555_0000; bus.s_wlast_i = 1'b1; bus.s_wvalid_i = 1'b1;
    repeat (2) begin
      chk("t6_wready_held", bus.s_wready_o, 1'b0);
      @(posedge clk); #1;
    end
    send_aw(5'd7, 32'h2000_0030);
    send_beats(1, 1, 32'h5555_0000);
    wait_b(0, bid, bresp);
    chk("t6_nwr", wr_log.size(), base + 1);
    chk("t6_addr", wr_log[base].addr, 12);
    chk("t6_data", wr_log[base].data, 32'h5555_0000);

    // Reset mid-burst, then a clean burst.
    send_aw(5'd8, 32'h2000_0000);
    send_beats(2, 4, 32'h6666_0000);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t7_no_b", bus.s_bvalid_o, 1'b0);
    end
    base = wr_log.size();
    send_aw(5'd9, 32'h2000_0004);
    send_beats(4, 4, 32'h7777_0000);
    wait_b(0, bid, bresp);
    chk("t7_bid", bid, 5'd9);
    chk("t7_bresp", bresp, 2'b00);
    chk("t7_nwr", wr_log.size(), base + 4);
    chk("t7_addr_last", wr_log[base+3].addr, 4);
    chk("t7_cnt", dut.u_frame_cnt.count_q, 3'd4);
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
